// File: rtl/eth_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_frame_tx                                                 |
// | Description : Byte-wide Ethernet frame transmitter. Accepts one header     |
// |               descriptor (dst MAC, src MAC, EtherType) per frame, emits    |
// |               the 14-byte header, passes the payload stream through and    |
// |               optionally zero-pads the frame up to MIN_FRAME_BYTES.        |
// |               Frame-status strobes mirror the receive-side FSM.            |
// | Ports       : clk, rst             - clock, synchronous active-high reset  |
// |               hdr_valid/hdr_ready  - header descriptor handshake           |
// |               hdr_dst_mac/_src_mac/_ethertype - header fields              |
// |               s_t*                 - byte-wide payload AXI-Stream input    |
// |               m_t*                 - byte-wide frame AXI-Stream output     |
// |               frame_start/_end     - registered one-cycle frame strobes    |
// |               in_header/_payload/_pad - current FSM state flags            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_frame_tx #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int PAD_EN          = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] hdr_dst_mac,
    input  logic [47:0] hdr_src_mac,
    input  logic [15:0] hdr_ethertype,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_start,
    output logic        frame_end,
    output logic        in_header,
    output logic        in_payload,
    output logic        in_pad
);

    localparam logic [1:0] c_s_idle    = 2'd0;
    localparam logic [1:0] c_s_header  = 2'd1;
    localparam logic [1:0] c_s_payload = 2'd2;
    localparam logic [1:0] c_s_pad     = 2'd3;

    localparam logic [3:0]  c_hdr_last  = 4'd13;
    localparam logic [16:0] c_min_bytes = 17'(MIN_FRAME_BYTES);
    // Index of the final padded byte; unused (never reached) when MIN is 0.
    localparam logic [15:0] c_pad_last  = (MIN_FRAME_BYTES > 0) ? 16'(MIN_FRAME_BYTES - 1) : 16'd0;

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [15:0]  r_byte_cnt;
    logic [111:0] r_hdr;
    logic         r_out_en;
    logic         r_frame_start;
    logic         r_frame_end;

    logic [111:0] w_hdr_shift;
    logic         w_m_beat;
    logic         w_hdr_accept;
    logic         w_pay_tlast;
    logic         w_pad_tlast;

    // Header byte N sits at the top of the latched header after shifting left by N bytes.
    assign w_hdr_shift  = r_hdr << {r_byte_cnt[3:0], 3'b000};
    assign w_m_beat     = m_tvalid && m_tready;
    assign w_hdr_accept = hdr_valid && hdr_ready;
    assign w_pay_tlast  = s_tlast && ((PAD_EN == 0) || (({1'b0, r_byte_cnt} + 17'd1) >= c_min_bytes));
    assign w_pad_tlast  = (r_byte_cnt == c_pad_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle: begin
                if (w_hdr_accept) w_next_state = c_s_header;
            end
            c_s_header: begin
                if (w_m_beat && (r_byte_cnt[3:0] == c_hdr_last)) w_next_state = c_s_payload;
            end
            c_s_payload: begin
                if (w_m_beat && s_tlast) w_next_state = m_tlast ? c_s_idle : c_s_pad;
            end
            c_s_pad: begin
                if (w_m_beat && w_pad_tlast) w_next_state = c_s_idle;
            end
            default: w_next_state = c_s_idle;
        endcase
    end

    // Output logic. Everything is forced low while rst is high so that an
    // aborted frame never shows a final beat, and hdr_ready waits one cycle
    // after reset release (r_out_en) before the first descriptor is taken.
    always_comb begin
        hdr_ready  = 1'b0;
        s_tready   = 1'b0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        m_tdata    = 8'h00;
        in_header  = 1'b0;
        in_payload = 1'b0;
        in_pad     = 1'b0;
        if (!rst) begin
            case (r_state)
                c_s_idle: begin
                    hdr_ready = r_out_en;
                end
                c_s_header: begin
                    m_tvalid  = 1'b1;
                    m_tdata   = w_hdr_shift[111:104];
                    in_header = 1'b1;
                end
                c_s_payload: begin
                    m_tdata    = s_tdata;
                    m_tvalid   = s_tvalid;
                    s_tready   = m_tready;
                    m_tlast    = w_pay_tlast;
                    in_payload = 1'b1;
                end
                c_s_pad: begin
                    m_tvalid = 1'b1;
                    m_tlast  = w_pad_tlast;
                    in_pad   = 1'b1;
                end
                default: begin
                    hdr_ready = 1'b0;
                end
            endcase
        end
    end

    // Datapath: header latch, beat counter, status strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en      <= 1'b0;
            r_byte_cnt    <= 16'd0;
            r_hdr         <= 112'd0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            if (w_next_state == c_s_idle) begin
                r_byte_cnt <= 16'd0;
            end else if (w_m_beat && (r_byte_cnt != 16'hFFFF)) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
            if (w_hdr_accept) begin
                r_hdr <= {hdr_dst_mac, hdr_src_mac, hdr_ethertype};
            end
            r_frame_start <= w_m_beat && (r_state == c_s_header) && (r_byte_cnt == 16'd0);
            r_frame_end   <= w_m_beat && m_tlast;
        end
    end

    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;

endmodule
`default_nettype wire
